// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if
// Bundles the request handshake, the ALU operand/result bus and the result
// handshake of the ALU issue stage.
//   slave  : the issue stage itself (accepts ops, drives ALU, drives results)
//   master : the surrounding logic (requester, external ALU, result consumer)
// Signals:
//   in_valid/in_ready, in_a, in_b, in_fsel, in_tag : op request handshake
//   alu_a, alu_b, alu_fsel / alu_result           : combinational ALU bus
//   out_valid/out_ready, out_result, out_tag, out_zero : result handshake
//   count                                         : FIFO occupancy
interface alu_issue_stage_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_fsel;
  logic [TAG_W-1:0] in_tag;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_fsel;
  logic [WIDTH-1:0] alu_result;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;

  logic [CNT_W-1:0] count;

  modport slave (
    input  in_valid, in_a, in_b, in_fsel, in_tag,
    output in_ready,
    output alu_a, alu_b, alu_fsel,
    input  alu_result,
    output out_valid, out_result, out_tag, out_zero,
    input  out_ready,
    output count
  );

  modport master (
    output in_valid, in_a, in_b, in_fsel, in_tag,
    input  in_ready,
    input  alu_a, alu_b, alu_fsel,
    output alu_result,
    input  out_valid, out_result, out_tag, out_zero,
    output out_ready,
    input  count
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage
// Issue/capture stage around a combinational 32-bit ALU. Ops are accepted
// over a valid/ready handshake into a DEPTH-entry FIFO; the head entry drives
// the ALU, and the ALU output is captured into a result register that has
// its own valid/ready handshake. Sustains one op per cycle with no stalls.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, drops all in-flight ops
//   bus   : alu_issue_stage_if.slave (request, ALU and result buses)
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  alu_issue_stage_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // FIFO storage carries no reset: pointers and count define what is live.
  logic [WIDTH-1:0] mem_a_q   [DEPTH];
  logic [WIDTH-1:0] mem_a_d   [DEPTH];
  logic [WIDTH-1:0] mem_b_q   [DEPTH];
  logic [WIDTH-1:0] mem_b_d   [DEPTH];
  logic [2:0]       mem_f_q   [DEPTH];
  logic [2:0]       mem_f_d   [DEPTH];
  logic [TAG_W-1:0] mem_t_q   [DEPTH];
  logic [TAG_W-1:0] mem_t_d   [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic             out_valid_q,  out_valid_d;
  logic [WIDTH-1:0] out_result_q, out_result_d;
  logic [TAG_W-1:0] out_tag_q,    out_tag_d;
  logic             out_zero_q,   out_zero_d;

  logic in_ready;
  logic fifo_empty;
  logic push;
  logic capture;

  // in_ready depends on registered occupancy only, so out_ready never
  // reaches it combinationally.
  assign in_ready   = (count_q < CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.in_valid && in_ready;
  assign capture    = !fifo_empty && (!out_valid_q || bus.out_ready);

  always_comb begin
    mem_a_d  = mem_a_q;
    mem_b_d  = mem_b_q;
    mem_f_d  = mem_f_q;
    mem_t_d  = mem_t_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_a_d[wr_ptr_q] = bus.in_a;
      mem_b_d[wr_ptr_q] = bus.in_b;
      mem_f_d[wr_ptr_q] = bus.in_fsel;
      mem_t_d[wr_ptr_q] = bus.in_tag;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    if (capture) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, capture})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    out_zero_d   = out_zero_q;

    if (capture) begin
      out_valid_d  = 1'b1;
      out_result_d = bus.alu_result;
      out_tag_d    = mem_t_q[rd_ptr_q];
      out_zero_d   = (bus.alu_result == '0);
    end else if (out_valid_q && bus.out_ready) begin
      // Result consumed with nothing to replace it; data holds its value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    mem_a_q <= mem_a_d;
    mem_b_q <= mem_b_d;
    mem_f_q <= mem_f_d;
    mem_t_q <= mem_t_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
      out_zero_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
      out_zero_q   <= out_zero_d;
    end
  end

  // An empty FIFO presents zeros so the ALU sees a quiet, known input.
  assign bus.alu_a    = fifo_empty ? '0   : mem_a_q[rd_ptr_q];
  assign bus.alu_b    = fifo_empty ? '0   : mem_b_q[rd_ptr_q];
  assign bus.alu_fsel = fifo_empty ? 3'b0 : mem_f_q[rd_ptr_q];

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = out_result_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.count      = count_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage
// Directed bench for alu_issue_stage with a behavioural model of the
// external combinational ALU attached to the ALU bus.
module tb_alu_issue_stage;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  alu_issue_stage_if #(.WIDTH(32), .DEPTH(2), .TAG_W(4)) bus ();

  alu_issue_stage #(.WIDTH(32), .DEPTH(2), .TAG_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model
  always_comb begin
    bus.alu_result = 32'd0;
    case (bus.alu_fsel)
      3'b000: bus.alu_result = bus.alu_a + bus.alu_b;
      3'b001: bus.alu_result = bus.alu_a - bus.alu_b;
      3'b010: bus.alu_result = ~bus.alu_a;
      3'b011: bus.alu_result = bus.alu_a & bus.alu_b;
      3'b100: bus.alu_result = bus.alu_a | bus.alu_b;
      3'b101: bus.alu_result = bus.alu_a ^ bus.alu_b;
      3'b110: bus.alu_result = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      3'b111: bus.alu_result = {31'd0, (bus.alu_a == bus.alu_b)};
      default: bus.alu_result = 32'd0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f, input logic [3:0] t);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_fsel  = f;
    bus.in_tag   = t;
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] f, input logic [3:0] t);
    drive(a, b, f, t);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (bus.count !== 2'd0) $display("FAIL reset_count got %0d want 0", bus.count); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_result !== 32'd0) $display("FAIL reset_out_result got %h want 0", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_tag !== 4'd0) $display("FAIL reset_out_tag got %h want 0", bus.out_tag); else n_pass++;
    n_checks++; if (bus.out_zero !== 1'b0) $display("FAIL reset_out_zero got %b want 0", bus.out_zero); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
  endtask

  task automatic test_single_add();
    bus.out_ready = 1'b1;
    drive(32'd5, 32'd3, 3'b000, 4'd1);
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL add_lat_valid1 got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.count !== 2'd1) $display("FAIL add_count got %0d want 1", bus.count); else n_pass++;
    n_checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd3 || bus.alu_fsel !== 3'b000)
      $display("FAIL add_alu_bus got %h/%h/%b want 5/3/000", bus.alu_a, bus.alu_b, bus.alu_fsel); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL add_lat_valid2 got %b want 1", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_result !== 32'd8) $display("FAIL add_result got %h want 8", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_tag !== 4'd1) $display("FAIL add_tag got %h want 1", bus.out_tag); else n_pass++;
    n_checks++; if (bus.out_zero !== 1'b0) $display("FAIL add_zero got %b want 0", bus.out_zero); else n_pass++;
    n_checks++; if (bus.count !== 2'd0) $display("FAIL add_count_after got %0d want 0", bus.count); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL add_drain got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_sub();
    bus.out_ready = 1'b1;
    send_one(32'd3, 32'd5, 3'b001, 4'd2);
    tick();
    n_checks++; if (bus.out_result !== 32'hFFFF_FFFE) $display("FAIL sub_underflow got %h want fffffffe", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_zero !== 1'b0 || bus.out_tag !== 4'd2)
      $display("FAIL sub_underflow_zero_tag got %b/%h want 0/2", bus.out_zero, bus.out_tag); else n_pass++;
    send_one(32'd7, 32'd7, 3'b001, 4'd3);
    tick();
    n_checks++; if (bus.out_result !== 32'd0) $display("FAIL sub_zero_result got %h want 0", bus.out_result); else n_pass++;
    n_checks++; if (bus.out_zero !== 1'b1) $display("FAIL sub_zero_flag got %b want 1", bus.out_zero); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a   [4];
    logic [31:0] b   [4];
    logic [2:0]  f   [4];
    logic [31:0] exp [4];
    a[0] = 32'hFFFF_FFFF; b[0] = 32'h0000_0000; f[0] = 3'b000; exp[0] = 32'hFFFF_FFFF;
    a[1] = 32'hF0F0_F0F0; b[1] = 32'hFF00_FF00; f[1] = 3'b011; exp[1] = 32'hF000_F000;
    a[2] = 32'hAAAA_5555; b[2] = 32'hFFFF_0000; f[2] = 3'b101; exp[2] = 32'h5555_5555;
    a[3] = 32'hFFFF_FFFF; b[3] = 32'h0000_0000; f[3] = 3'b110; exp[3] = 32'h0000_0001;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready op%0d got %b want 1", i, bus.in_ready); else n_pass++;
      drive(a[i], b[i], f[i], 4'(i));
      tick();
      if (i > 0) begin
        n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== exp[i-1] || bus.out_tag !== 4'(i-1))
          $display("FAIL b2b_result op%0d got v=%b %h tag %h want v=1 %h tag %0d",
                   i-1, bus.out_valid, bus.out_result, bus.out_tag, exp[i-1], i-1); else n_pass++;
      end
    end
    bus.in_valid = 1'b0;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd1 || bus.out_tag !== 4'd3)
      $display("FAIL b2b_slt got v=%b %h tag %h want v=1 1 tag 3", bus.out_valid, bus.out_result, bus.out_tag); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_drain got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    send_one(32'd10, 32'd20, 3'b000, 4'd4);
    send_one(32'd100, 32'd1, 3'b001, 4'd5);
    send_one(32'h0F, 32'hF0, 3'b100, 4'd6);
    drive(32'd9, 32'd9, 3'b111, 4'd7);
    #1;
    n_checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b want 0", bus.in_ready); else n_pass++;
    n_checks++; if (bus.count !== 2'd2) $display("FAIL bp_count got %0d want 2", bus.count); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL bp_out_valid got %b want 1", bus.out_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.out_result !== 32'd30 || bus.out_tag !== 4'd4 || bus.count !== 2'd2)
        $display("FAIL bp_hold cyc%0d got %h tag %h cnt %0d want 1e tag 4 cnt 2", i, bus.out_result, bus.out_tag, bus.count); else n_pass++;
    end
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_result !== 32'd99 || bus.out_tag !== 4'd5 || bus.count !== 2'd1)
      $display("FAIL bp_drain1 got %h tag %h cnt %0d want 63 tag 5 cnt 1", bus.out_result, bus.out_tag, bus.count); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_reopen got %b want 1", bus.in_ready); else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n_checks++; if (bus.out_result !== 32'hFF || bus.out_tag !== 4'd6 || bus.count !== 2'd1)
      $display("FAIL bp_drain2 got %h tag %h cnt %0d want ff tag 6 cnt 1", bus.out_result, bus.out_tag, bus.count); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd1 || bus.out_tag !== 4'd7 || bus.count !== 2'd0)
      $display("FAIL bp_fourth got v=%b %h tag %h cnt %0d want v=1 1 tag 7 cnt 0",
               bus.out_valid, bus.out_result, bus.out_tag, bus.count); else n_pass++;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_empty_idle();
    bus.in_valid = 1'b0;
    bus.in_a     = 32'hDEAD_BEEF;
    bus.in_b     = 32'h1234_5678;
    bus.in_fsel  = 3'b101;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0 || bus.alu_fsel !== 3'b000)
        $display("FAIL idle_alu_bus got %h/%h/%b want 0/0/000", bus.alu_a, bus.alu_b, bus.alu_fsel); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0)
        $display("FAIL idle_state got v=%b cnt %0d want v=0 cnt 0", bus.out_valid, bus.count); else n_pass++;
    end
  endtask

  task automatic test_midop_reset();
    bus.out_ready = 1'b0;
    send_one(32'd11, 32'd22, 3'b000, 4'd8);
    send_one(32'd33, 32'd44, 3'b000, 4'd9);
    send_one(32'd55, 32'd66, 3'b000, 4'd10);
    n_checks++; if (bus.count !== 2'd2 || bus.out_valid !== 1'b1)
      $display("FAIL rst_setup got cnt %0d v=%b want cnt 2 v=1", bus.count, bus.out_valid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.count !== 2'd0) $display("FAIL rst_mid_count got %0d want 0", bus.count); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_mid_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_result !== 32'd0) $display("FAIL rst_mid_result got %h want 0", bus.out_result); else n_pass++;
    #2;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    n_checks++; if (bus.out_valid !== 1'b0 || bus.count !== 2'd0)
      $display("FAIL rst_no_partial got v=%b cnt %0d want v=0 cnt 0", bus.out_valid, bus.count); else n_pass++;
    send_one(32'd1, 32'd1, 3'b111, 4'd3);
    tick();
    n_checks++; if (bus.out_valid !== 1'b1 || bus.out_result !== 32'd1 || bus.out_tag !== 4'd3)
      $display("FAIL rst_after_eq got v=%b %h tag %h want v=1 1 tag 3", bus.out_valid, bus.out_result, bus.out_tag); else n_pass++;
    tick();
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_fsel   = 3'b000;
    bus.in_tag    = 4'd0;
    bus.out_ready = 1'b0;
    #2;
    test_reset();
    #10;
    rst_n = 1'b1;
    tick();
    test_single_add();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_empty_idle();
    test_midop_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
